// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative 16-bit multiply/divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mdu_pkg;

  localparam int WIDTH  = 16;  // operand / result width
  localparam int ADDR_W = 3;   // register-file address width
  localparam int ITER   = 16;  // iterations per operation (= WIDTH)

  // Operation encodings; op[1] distinguishes the divide class.
  localparam logic [1:0] OP_MUL  = 2'b00;  // low half of product
  localparam logic [1:0] OP_MULH = 2'b01;  // high half of product
  localparam logic [1:0] OP_DIV  = 2'b10;  // quotient
  localparam logic [1:0] OP_REM  = 2'b11;  // remainder

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } state_t;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mdu_step_16_bit.sv
// One combinational iteration of shift-add multiply or restoring divide.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; evaluated every cycle, the caller decides when to use it.
//
// Ports:
//   is_div   - 1: restoring-divide step, 0: shift-add multiply step
//   acc      - 2*WIDTH accumulator ({product} or {remainder, quotient})
//   operand  - multiplicand (MUL) or divisor (DIV)
//   in_bit   - current multiplier bit (MUL) or next dividend bit, MSB first (DIV)
//   acc_next - accumulator after this step
//   q_bit    - quotient bit produced by this step (0 for multiply)
module mdu_step_16_bit #(
  parameter int WIDTH = mdu_pkg::WIDTH
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               in_bit,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               q_bit
);

  logic [WIDTH:0]   mul_sum;    // high half plus multiplicand, with carry
  logic [WIDTH:0]   rem_shift;  // remainder shifted left with next dividend bit
  logic [WIDTH-1:0] rem_sub;    // rem_shift - divisor, only kept when it fits
  logic             rem_ge;

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (in_bit ? {1'b0, operand} : '0);
    rem_shift = {acc[2*WIDTH-1:WIDTH], in_bit};
    rem_ge    = (rem_shift >= {1'b0, operand});
    // The remainder stays below the divisor, so a successful subtract
    // always fits back into WIDTH bits.
    rem_sub   = WIDTH'(rem_shift - {1'b0, operand});
    q_bit     = is_div & rem_ge;

    if (is_div) begin
      // Low half collects quotient bits MSB first.
      acc_next = {(rem_ge ? rem_sub : rem_shift[WIDTH-1:0]), acc[WIDTH-2:0], q_bit};
    end else begin
      // Carry out of the add becomes the new MSB after the right shift.
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/multiply_divide_unit_16_bit.sv
// Iterative unsigned multiply/divide unit returning its result on a register-file write port.
// Latency: fixed 18 cycles (start, 16 RUN iterations, one WB cycle), independent of operands.
// Backpressure: busy stalls the issuer; start while busy is dropped, nothing is queued.
//
// Ports:
//   clk, clr            - clock, async active-low reset
//   start/op            - request and operation (MUL, MULH, DIV, REM)
//   operand_a/b         - multiplicand/dividend and multiplier/divisor, latched at start
//   dest_addr           - destination register, latched at start
//   busy                - operation in flight
//   done, div_by_zero   - WB-cycle status
//   Write_En/Addr/Data  - register-file write port, active only in WB
module multiply_divide_unit_16_bit #(
  parameter int WIDTH  = mdu_pkg::WIDTH,
  parameter int ADDR_W = mdu_pkg::ADDR_W,
  parameter int ITER   = mdu_pkg::ITER
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  operand_a,
  input  logic [WIDTH-1:0]  operand_b,
  input  logic [ADDR_W-1:0] dest_addr,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
  output logic              Write_En,
  output logic [ADDR_W-1:0] Write_Addr,
  output logic [WIDTH-1:0]  Write_Data
);

  import mdu_pkg::*;

  localparam int CNT_W = $clog2(ITER);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [ADDR_W-1:0]  dest_q;
  logic [2*WIDTH-1:0] acc;

  logic               is_div;
  logic               in_bit;
  logic [WIDTH-1:0]   step_operand;
  logic [2*WIDTH-1:0] acc_next;
  logic               q_bit_unused;

  // Multiply walks the multiplier LSB first; divide feeds dividend bits MSB first.
  always_comb begin
    is_div       = op_is_div(op_q);
    in_bit       = is_div ? a_q[LAST - count] : b_q[count];
    step_operand = is_div ? b_q : a_q;
  end

  mdu_step_16_bit #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div),
    .acc      (acc),
    .operand  (step_operand),
    .in_bit   (in_bit),
    .acc_next (acc_next),
    .q_bit    (q_bit_unused)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state  <= IDLE;
      count  <= '0;
      op_q   <= OP_MUL;
      a_q    <= '0;
      b_q    <= '0;
      dest_q <= '0;
      acc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            a_q    <= operand_a;
            b_q    <= operand_b;
            dest_q <= dest_addr;
            acc    <= '0;
            count  <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_next;
          count <= count + CNT_W'(1);
          if (count == LAST) begin
            state <= WB;
          end
        end
        WB: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode registered state only, so nothing combinational reaches
  // the write port from start/op/operands.
  always_comb begin
    busy        = (state != IDLE);
    done        = 1'b0;
    Write_En    = 1'b0;
    Write_Addr  = '0;
    Write_Data  = '0;
    div_by_zero = 1'b0;
    if (state == WB) begin
      done        = 1'b1;
      Write_En    = 1'b1;
      Write_Addr  = dest_q;
      div_by_zero = is_div && (b_q == '0);
      // MUL/DIV read the low half (product low / quotient),
      // MULH/REM read the high half (product high / remainder).
      Write_Data  = op_q[0] ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_multiply_divide_unit_16_bit.sv
// Self-checking bench for multiply_divide_unit_16_bit: directed table, random ops
// against an arithmetic reference model, and busy/reset/back-to-back sequences.
module tb_multiply_divide_unit_16_bit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [1:0]  op;
  logic [15:0] operand_a;
  logic [15:0] operand_b;
  logic [2:0]  dest_addr;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic        Write_En;
  logic [2:0]  Write_Addr;
  logic [15:0] Write_Data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multiply_divide_unit_16_bit dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .dest_addr   (dest_addr),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .Write_En    (Write_En),
    .Write_Addr  (Write_Addr),
    .Write_Data  (Write_Data)
  );

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  dest;
    logic [15:0] exp_data;
    logic        exp_dz;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model straight from the arithmetic definition.
  function automatic logic [15:0] ref_result(input logic [1:0] o, input logic [15:0] a,
                                             input logic [15:0] b);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    case (o)
      OP_MUL:  return p[15:0];
      OP_MULH: return p[31:16];
      OP_DIV:  return (b == 16'h0) ? 16'hFFFF : a / b;
      default: return (b == 16'h0) ? a : a % b;
    endcase
  endfunction

  function automatic logic ref_dz(input logic [1:0] o, input logic [15:0] b);
    return o[1] && (b == 16'h0);
  endfunction

  // Move to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op at the current cycle (unit must be idle) and check the full timeline.
  task automatic run_op(input string nm, input logic [1:0] v_op, input logic [15:0] v_a,
                        input logic [15:0] v_b, input logic [2:0] v_dest,
                        input logic [15:0] exp_data, input logic exp_dz);
    int run_err;
    run_err   = 0;
    start     = 1'b1;
    op        = v_op;
    operand_a = v_a;
    operand_b = v_b;
    dest_addr = v_dest;
    @(negedge clk);
    check({nm, "/busy_c0"}, 32'(busy), 32'd0);
    for (int c = 1; c <= 18; c++) begin
      tick();
      // Scramble inputs after start: the unit must use its latched copies.
      start     = 1'b0;
      op        = 2'($urandom_range(0, 3));
      operand_a = 16'($urandom);
      operand_b = 16'($urandom);
      dest_addr = 3'($urandom);
      @(negedge clk);
      if (c <= 16) begin
        if (busy !== 1'b1 || Write_En !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0 ||
            Write_Data !== 16'h0 || Write_Addr !== 3'h0)
          run_err++;
      end else if (c == 17) begin
        check({nm, "/we_c17"},   32'(Write_En),    32'd1);
        check({nm, "/done_c17"}, 32'(done),        32'd1);
        check({nm, "/busy_c17"}, 32'(busy),        32'd1);
        check({nm, "/addr"},     32'(Write_Addr),  32'(v_dest));
        check({nm, "/data"},     32'(Write_Data),  32'(exp_data));
        check({nm, "/dz"},       32'(div_by_zero), 32'(exp_dz));
      end else begin
        check({nm, "/busy_c18"}, 32'(busy),     32'd0);
        check({nm, "/we_c18"},   32'(Write_En), 32'd0);
      end
    end
    check({nm, "/run_phase"}, 32'(run_err), 32'd0);
    tick();
  endtask

  initial begin
    int writes;
    int wcyc;
    int nwr;
    int wr_cyc[2];
    logic [15:0] wr_dat[2];
    logic [2:0]  wr_adr[2];
    logic [15:0] wdata;
    logic [2:0]  waddr;
    logic [1:0]  r_op;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [2:0]  r_d;

    vecs[0] = '{OP_MUL,  16'h1234, 16'h0010, 3'd3, 16'h2340, 1'b0};
    vecs[1] = '{OP_MULH, 16'hFFFF, 16'hFFFF, 3'd5, 16'hFFFE, 1'b0};
    vecs[2] = '{OP_MUL,  16'hFFFF, 16'hFFFF, 3'd5, 16'h0001, 1'b0};
    vecs[3] = '{OP_DIV,  16'd100,  16'd7,    3'd1, 16'h000E, 1'b0};
    vecs[4] = '{OP_REM,  16'd100,  16'd7,    3'd2, 16'h0002, 1'b0};
    vecs[5] = '{OP_DIV,  16'h1234, 16'h0000, 3'd6, 16'hFFFF, 1'b1};
    vecs[6] = '{OP_REM,  16'h1234, 16'h0000, 3'd7, 16'h1234, 1'b1};
    vecs[7] = '{OP_MUL,  16'h0000, 16'hFFFF, 3'd0, 16'h0000, 1'b0};
    vecs[8] = '{OP_DIV,  16'hFFFF, 16'h0001, 3'd4, 16'hFFFF, 1'b0};
    vecs[9] = '{OP_REM,  16'h0005, 16'h0009, 3'd2, 16'h0005, 1'b0};

    clr = 1'b0; start = 1'b0; op = 2'd0;
    operand_a = 16'h0; operand_b = 16'h0; dest_addr = 3'd0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/done", 32'(done), 32'd0);
    check("rst/we",   32'(Write_En), 32'd0);
    check("rst/addr", 32'(Write_Addr), 32'd0);
    check("rst/data", 32'(Write_Data), 32'd0);
    check("rst/dz",   32'(div_by_zero), 32'd0);
    tick();
    clr = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("idle/busy", 32'(busy), 32'd0);
    check("idle/we",   32'(Write_En), 32'd0);
    tick();

    // Directed table.
    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dest,
             vecs[i].exp_data, vecs[i].exp_dz);

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       r_b = 16'h0;
        1:       r_b = 16'($urandom_range(1, 15));
        default: r_b = 16'($urandom);
      endcase
      r_d = 3'($urandom);
      run_op($sformatf("rnd%0d", i), r_op, r_a, r_b, r_d, ref_result(r_op, r_a, r_b),
             ref_dz(r_op, r_b));
    end

    // Start pulse during an operation is ignored.
    writes = 0; wcyc = -1; wdata = 16'h0; waddr = 3'd0;
    for (int c = 0; c <= 40; c++) begin
      if (c == 0) begin
        start = 1'b1; op = OP_MUL; operand_a = 16'h0003; operand_b = 16'h0005; dest_addr = 3'd1;
      end else if (c == 5) begin
        start = 1'b1; op = OP_MUL; operand_a = 16'h0007; operand_b = 16'h0007; dest_addr = 3'd6;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (Write_En === 1'b1) begin
        writes++; wcyc = c; wdata = Write_Data; waddr = Write_Addr;
      end
      tick();
    end
    check("ign/writes", 32'(writes), 32'd1);
    check("ign/cycle",  32'(wcyc),   32'd17);
    check("ign/data",   32'(wdata),  32'd15);
    check("ign/addr",   32'(waddr),  32'd1);

    // Reset mid-operation aborts with no write.
    writes = 0;
    for (int c = 0; c <= 20; c++) begin
      if (c == 0) begin
        start = 1'b1; op = OP_DIV; operand_a = 16'd1000; operand_b = 16'd3; dest_addr = 3'd2;
      end else begin
        start = 1'b0;
      end
      if (c == 8) begin
        clr = 1'b0;
        #1;
        check("abort/busy", 32'(busy), 32'd0);
        check("abort/we",   32'(Write_En), 32'd0);
      end
      if (c == 10) clr = 1'b1;
      @(negedge clk);
      if (Write_En === 1'b1) writes++;
      tick();
    end
    check("abort/writes", 32'(writes), 32'd0);

    // Back-to-back: second start accepted in cycle 18.
    nwr = 0;
    for (int c = 0; c <= 40; c++) begin
      if (c == 0) begin
        start = 1'b1; op = OP_MULH; operand_a = 16'hABCD; operand_b = 16'h1234; dest_addr = 3'd4;
      end else if (c == 18) begin
        start = 1'b1; op = OP_REM; operand_a = 16'hBEEF; operand_b = 16'h0123; dest_addr = 3'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (c == 18) check("b2b/busy_c18", 32'(busy), 32'd0);
      if (Write_En === 1'b1) begin
        if (nwr < 2) begin
          wr_cyc[nwr] = c; wr_dat[nwr] = Write_Data; wr_adr[nwr] = Write_Addr;
        end
        nwr++;
      end
      tick();
    end
    check("b2b/writes", 32'(nwr), 32'd2);
    if (nwr >= 2) begin
      check("b2b/cyc0",  32'(wr_cyc[0]), 32'd17);
      check("b2b/dat0",  32'(wr_dat[0]), 32'(ref_result(OP_MULH, 16'hABCD, 16'h1234)));
      check("b2b/adr0",  32'(wr_adr[0]), 32'd4);
      check("b2b/cyc1",  32'(wr_cyc[1]), 32'd35);
      check("b2b/dat1",  32'(wr_dat[1]), 32'(ref_result(OP_REM, 16'hBEEF, 16'h0123)));
      check("b2b/adr1",  32'(wr_adr[1]), 32'd7);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multiply_divide_unit_16_bit.md
# multiply_divide_unit_16_bit

Iterative unsigned 16-bit multiply/divide unit for the single-cycle RISC core. It consumes the two register-file read ports (OutA/OutB) as operands and produces a register-file write port (Write_En/Write_Addr/Write_Data) to return the result. The unit takes a fixed 18 cycles per operation. It raises `busy` so the control path stalls the PC while an operation is in flight.

## Interface
Parameters:
- WIDTH, 16, operand/result width
- ADDR_W, 3, register address width (8 registers)
- ITER, 16, iterations per operation (= WIDTH)

Ports:
- clk  in  1  rising-edge clock
- clr  in  1  reset, asynchronous, active-low
- start  in  1  request; sampled only while busy=0
- op  in  2  00 MUL (low half), 01 MULH (high half), 10 DIV (quotient), 11 REM (remainder)
- operand_a  in  WIDTH  multiplicand / dividend (from OutA)
- operand_b  in  WIDTH  multiplier / divisor (from OutB)
- dest_addr  in  ADDR_W  destination register
- busy  out  1  operation in flight (state != IDLE)
- done  out  1  one-cycle pulse in the WB cycle
- div_by_zero  out  1  valid with done; 1 iff op is DIV/REM and divisor was 0
- Write_En  out  1  register-file write enable
- Write_Addr  out  ADDR_W  register-file write address
- Write_Data  out  WIDTH  register-file write data

## Operation
- States are IDLE, RUN and WB.
- IDLE:
  - If start=1, latch op, operand_a, operand_b and dest_addr, clear the 32-bit accumulator, set count=0, and go to RUN.
  - If start=0, stay in IDLE.
- RUN: perform one iteration per cycle and increment count. After the iteration with count=15, go to WB.
- MUL/MULH use shift-add:
  - Each step conditionally adds the multiplicand into the high half of the 32-bit product, then shifts right by 1.
  - The final product is exact: 32 bits, no overflow.
- DIV/REM use restoring division:
  - Each step shifts the remainder left with the next dividend bit.
  - The remainder is compared with the divisor using a 17-bit subtract.
  - If the remainder >= divisor, subtract and set the quotient bit to 1.
- Divisor 0 is not special-cased in the datapath. The natural result is quotient 0xFFFF and remainder = dividend. div_by_zero=1 in the WB cycle.
- WB:
  - Write_En=1, done=1, Write_Addr=latched dest_addr.
  - Write_Data selects by op: product[15:0] for MUL, product[31:16] for MULH, quotient for DIV, remainder for REM.
  - Always go to IDLE next.
- Outside WB: Write_En=0, done=0, div_by_zero=0, Write_Data=0, Write_Addr=0.
- start while busy=1 is ignored; nothing is queued.
- Operands are latched at start; later changes to OutA/OutB have no effect.
- All arithmetic is unsigned.

## Timing
- Reset (clr=0, any time): go to IDLE immediately. All outputs are 0 and count=0.
  - Reset mid-operation aborts the operation with no write.
- Cycle 0: start=1 with busy=0.
- Cycles 1–16: RUN, busy=1.
- Cycle 17: WB, busy=1, Write_En=1, done=1. The register file captures the result on the edge ending cycle 17.
- Cycle 18: busy=0. A new start is accepted here, giving back-to-back throughput of one operation per 18 cycles.
- The result register is readable through OutA/OutB from cycle 18.
- Latency is fixed and independent of operand values.
- Write_En/Write_Addr/Write_Data are registered-state decodes: no combinational path from start, op or the operands.

## Structure
- Package mdu_pkg holds:
  - op encodings (OP_MUL, OP_MULH, OP_DIV, OP_REM)
  - state encoding (IDLE, RUN, WB)
  - WIDTH, ADDR_W, ITER constants
- One sub-module is natural: mdu_step_16_bit.
  - Combinational single iteration.
  - Inputs: op class, accumulator, operand.
  - Outputs: next accumulator and quotient bit.
- The top module holds the FSM, counter, operand latches and write-port decode.

## Test plan
- Reset with no start → all outputs 0 and busy=0.
- MUL 0x1234×0x0010, dest 3 → cycle 17: Write_En=1, Write_Addr=3, Write_Data=0x2340, done=1, div_by_zero=0.
- MULH 0xFFFF×0xFFFF, dest 5 → Write_Data=0xFFFE. MUL with the same operands → 0x0001.
- DIV 100÷7 → Write_Data=0x000E. REM 100÷7 → 0x0002.
- DIV 0x1234÷0 → Write_Data=0xFFFF, div_by_zero=1. REM 0x1234÷0 → Write_Data=0x1234, div_by_zero=1.
- Busy/reset checks, in one run:
  - start pulse at cycle 5 of an operation → ignored, exactly one write.
  - clr low at cycle 8 → busy=0 immediately, no Write_En through cycle 20.
  - start at cycle 18 after a completed op → accepted, write at cycle 35.
